lock_code_ctrl: RTL and testbench

Code-entry controller for the board's electronic lock. It debounces four push-buttons and a power switch, collects a 4-symbol code, and compares it with a parameterised secret. It drives the 3-bit display state code and the one-cycle buzz pulse consumed by the downstream 7-segment/buzzer driver: 001 "Err", 010 "On", 011 "OFF", 100 "OPEn".

---
 rtl/lock_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 50 +++++
 rtl/lock_code_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lock_code_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the lock code-entry controller.
// Display codes are also consumed by the 7-segment/buzzer driver.
package lock_pkg;

  localparam logic [2:0] CODE_ERR  = 3'b001;
  localparam logic [2:0] CODE_ON   = 3'b010;
  localparam logic [2:0] CODE_OFF  = 3'b011;
  localparam logic [2:0] CODE_OPEN = 3'b100;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_IDLE    = 3'd1,
    S_ENTRY   = 3'd2,
    S_CHECK   = 3'd3,
    S_OPEN    = 3'd4,
    S_ERR     = 3'd5,
    S_LOCKOUT = 3'd6
  } fsm_e;

  function automatic logic [2:0] state_code(input fsm_e s);
    logic [2:0] c;
    unique case (s)
      S_OFF:            c = CODE_OFF;
      S_OPEN:           c = CODE_OPEN;
      S_ERR, S_LOCKOUT: c = CODE_ERR;
      default:          c = CODE_ON;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-run debouncer.
// Output flips after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == LAST) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/lock_code_ctrl.sv
// Electronic lock code-entry controller: debounced buttons, 4-symbol
// code collection, secret compare, timed OPEN/ERR/LOCKOUT display states.
module lock_code_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [7:0]  SECRET          = 8'b00_01_10_11,
  parameter int unsigned OPEN_CYCLES     = 250_000_000,
  parameter int unsigned ERR_CYCLES      = 100_000_000,
  parameter int unsigned LOCKOUT_CYCLES  = 1_500_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic       power_sw,
  output logic [2:0] state,
  output logic       buzz,
  output logic [2:0] entry_cnt
);

  import lock_pkg::*;

  localparam logic [31:0] OPEN_LD = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0] ERR_LD  = 32'(ERR_CYCLES - 1);
  localparam logic [31:0] LOCK_LD = 32'(LOCKOUT_CYCLES - 1);
  localparam logic [31:0] TO_LD   = 32'(TIMEOUT_CYCLES - 1);

  logic [4:0]  raw;
  logic [4:0]  db;
  logic [3:0]  prev_q;
  logic [3:0]  rise;
  logic        press_vld;
  logic [1:0]  press_sym;
  logic        pwr;

  fsm_e        fsm_q;
  fsm_e        fsm_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [1:0]  fail_q;
  logic [1:0]  fail_d;
  logic [31:0] timer_q;
  logic [31:0] timer_d;
  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic        buzz_q;
  logic        buzz_d;

  assign raw = {power_sw, btn};

  for (genvar i = 0; i < 5; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (raw[i]),
      .dout (db[i])
    );
  end

  assign pwr  = db[4];
  assign rise = db[3:0] & ~prev_q;

  // Simultaneous presses: lowest index wins.
  always_comb begin
    press_vld = |rise;
    press_sym = 2'd0;
    priority case (1'b1)
      rise[0]: press_sym = 2'd0;
      rise[1]: press_sym = 2'd1;
      rise[2]: press_sym = 2'd2;
      rise[3]: press_sym = 2'd3;
      default: press_sym = 2'd0;
    endcase
  end

  always_comb begin
    fsm_d   = fsm_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    buzz_d  = 1'b0;
    if (!pwr) begin
      fsm_d   = S_OFF;
      shift_d = '0;
      cnt_d   = '0;
      fail_d  = '0;
      timer_d = '0;
    end else begin
      unique case (fsm_q)
        S_OFF: fsm_d = S_IDLE;
        S_IDLE: begin
          if (press_vld) begin
            shift_d = {6'd0, press_sym};
            cnt_d   = 3'd1;
            timer_d = TO_LD;
            fsm_d   = S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (press_vld) begin
            shift_d = {shift_q[5:0], press_sym};
            cnt_d   = cnt_q + 3'd1;
            timer_d = TO_LD;
            if (cnt_q == 3'd3) begin
              fsm_d = S_CHECK;
            end
          end else if (timer_q == '0) begin
            shift_d = '0;
            cnt_d   = '0;
            fsm_d   = S_IDLE;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        S_CHECK: begin
          cnt_d = '0;
          if (shift_q == SECRET) begin
            fail_d  = '0;
            timer_d = OPEN_LD;
            fsm_d   = S_OPEN;
          end else begin
            fail_d = fail_q + 2'd1;
            buzz_d = 1'b1;
            if (fail_q == 2'd2) begin
              timer_d = LOCK_LD;
              fsm_d   = S_LOCKOUT;
            end else begin
              timer_d = ERR_LD;
              fsm_d   = S_ERR;
            end
          end
        end
        S_OPEN, S_ERR, S_LOCKOUT: begin
          if (timer_q == '0) begin
            fsm_d = S_IDLE;
            if (fsm_q == S_LOCKOUT) begin
              fail_d = '0;
            end
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        default: fsm_d = S_OFF;
      endcase
    end
    state_d = state_code(fsm_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      fsm_q   <= S_OFF;
      shift_q <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      state_q <= CODE_OFF;
      buzz_q  <= 1'b0;
    end else begin
      prev_q  <= db[3:0];
      fsm_q   <= fsm_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      state_q <= state_d;
      buzz_q  <= buzz_d;
    end
  end

  assign state     = state_q;
  assign buzz      = buzz_q;
  assign entry_cnt = cnt_q;

endmodule

// File: tb/tb_lock_code_ctrl.sv
// Bench for lock_code_ctrl: code-attempt table, corner sequences
// and random stimulus, all tracked by a per-cycle reference model.
module tb_lock_code_ctrl;
  import lock_pkg::*;

  localparam int DB   = 4;
  localparam int OPN  = 20;
  localparam int ERC  = 10;
  localparam int LCK  = 40;
  localparam int TO   = 50;
  localparam logic [7:0] SEC = 8'b00_01_10_11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn = 4'd0;
  logic       power_sw = 1'b1;
  logic [2:0] state;
  logic       buzz;
  logic [2:0] entry_cnt;

  always #5 clk = ~clk;

  lock_code_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .SECRET         (SEC),
    .OPEN_CYCLES    (OPN),
    .ERR_CYCLES     (ERC),
    .LOCKOUT_CYCLES (LCK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .power_sw (power_sw),
    .state    (state),
    .buzz     (buzz),
    .entry_cnt(entry_cnt)
  );

  typedef enum int {M_OFF, M_IDLE, M_ENTRY, M_CHECK, M_OPEN, M_ERR, M_LOCK} mmode_t;

  mmode_t    mode;
  int        code_q[$];
  int        fails;
  int        idle;
  int        left;
  bit        mbuzz;
  bit [31:0] raw_h[5];
  bit [31:0] syn_h[5];
  bit        db[5];
  bit        dbp[5];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] code;
    logic [2:0] st;
    int         len;
    int         bz;
  } vec_t;

  vec_t vecs[5];

  function automatic void model_reset();
    mode = M_OFF;
    code_q.delete();
    fails = 0;
    idle  = 0;
    left  = 0;
    mbuzz = 1'b0;
    for (int i = 0; i < 5; i++) begin
      raw_h[i] = '0;
      syn_h[i] = '0;
      db[i]    = 1'b0;
      dbp[i]   = 1'b0;
    end
  endfunction

  function automatic void model_edge(input bit [4:0] raw);
    int sym;
    int code;
    bit s;
    bit [31:0] mask;
    sym = -1;
    for (int i = 3; i >= 0; i--) if (db[i] && !dbp[i]) sym = i;
    mbuzz = 1'b0;
    if (!db[4]) begin
      mode = M_OFF;
      code_q.delete();
      fails = 0;
    end else begin
      case (mode)
        M_OFF: mode = M_IDLE;
        M_IDLE: if (sym >= 0) begin
          code_q.delete();
          code_q.push_back(sym);
          idle = 0;
          mode = M_ENTRY;
        end
        M_ENTRY: if (sym >= 0) begin
          code_q.push_back(sym);
          idle = 0;
          if (code_q.size() == 4) mode = M_CHECK;
        end else begin
          idle++;
          if (idle == TO) begin
            code_q.delete();
            mode = M_IDLE;
          end
        end
        M_CHECK: begin
          code = 0;
          foreach (code_q[k]) code = code * 4 + code_q[k];
          code_q.delete();
          if (code == int'(SEC)) begin
            fails = 0;
            mode = M_OPEN;
            left = OPN;
          end else begin
            fails++;
            mbuzz = 1'b1;
            if (fails == 3) begin
              mode = M_LOCK;
              left = LCK;
            end else begin
              mode = M_ERR;
              left = ERC;
            end
          end
        end
        default: begin
          left--;
          if (left == 0) begin
            if (mode == M_LOCK) fails = 0;
            mode = M_IDLE;
          end
        end
      endcase
    end
    mask = (32'd1 << DB) - 32'd1;
    for (int i = 0; i < 5; i++) begin
      raw_h[i] = {raw_h[i][30:0], raw[i]};
      s = raw_h[i][2];
      syn_h[i] = {syn_h[i][30:0], s};
      dbp[i] = db[i];
      if (db[i] ? ((syn_h[i] & mask) == 0) : ((syn_h[i] & mask) == mask))
        db[i] = s;
    end
  endfunction

  function automatic int exp_state();
    case (mode)
      M_OFF:         return int'(CODE_OFF);
      M_OPEN:        return int'(CODE_OPEN);
      M_ERR, M_LOCK: return int'(CODE_ERR);
      default:       return int'(CODE_ON);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge({power_sw, btn});
    else model_reset();
    @(negedge clk);
    chk("model_state", int'(state), exp_state());
    chk("model_entry_cnt", int'(entry_cnt), code_q.size());
    chk("model_buzz", int'(buzz), int'(mbuzz));
  endtask

  task automatic press(input int sym);
    btn = 4'd1 << sym;
    repeat (DB + 4) tick();
    btn = 4'd0;
    repeat (DB + 4) tick();
  endtask

  task automatic wait_on();
    int n;
    n = 0;
    while (state !== CODE_ON && n < 200) begin
      tick();
      n++;
    end
    chk("wait_on", int'(state), int'(CODE_ON));
  endtask

  task automatic try_code(input logic [7:0] code, input logic [2:0] st,
                          input int len, input int bz_exp);
    int n;
    int run;
    int bz;
    int last_cnt;
    for (int i = 0; i < 3; i++) begin
      press(int'(code[7-2*i -: 2]));
      chk("entry_cnt_step", int'(entry_cnt), i + 1);
    end
    btn = 4'd1 << code[1:0];
    n = 0;
    last_cnt = 0;
    while (state == CODE_ON && n < 30) begin
      last_cnt = int'(entry_cnt);
      tick();
      n++;
    end
    btn = 4'd0;
    chk("check_entry_cnt", last_cnt, 4);
    run = 0;
    bz = 0;
    while (state == st && run < 200) begin
      run++;
      bz += int'(buzz);
      tick();
    end
    chk("timed_len", run, len);
    chk("buzz_count", bz, bz_exp);
    chk("after_timed", int'(state), int'(CODE_ON));
  endtask

  initial begin
    int n;
    int bz;
    vecs[0] = '{8'b00_01_10_11, CODE_OPEN, OPN, 0};
    vecs[1] = '{8'b11_11_11_11, CODE_ERR,  ERC, 1};
    vecs[2] = '{8'b00_01_10_10, CODE_ERR,  ERC, 1};
    vecs[3] = '{8'b01_00_10_11, CODE_ERR,  LCK, 1};
    vecs[4] = '{8'b00_01_10_11, CODE_OPEN, OPN, 0};

    model_reset();
    #2 rst_n = 1'b0;
    power_sw = 1'b1;
    repeat (3) tick();
    chk("reset_state", int'(state), int'(CODE_OFF));
    chk("reset_cnt", int'(entry_cnt), 0);
    chk("reset_buzz", int'(buzz), 0);
    rst_n = 1'b1;
    wait_on();

    foreach (vecs[v]) try_code(vecs[v].code, vecs[v].st, vecs[v].len, vecs[v].bz);

    btn = 4'b0001;
    repeat (2) tick();
    btn = 4'd0;
    repeat (12) tick();
    chk("glitch_cnt", int'(entry_cnt), 0);

    btn = 4'b0101;
    repeat (DB + 4) tick();
    btn = 4'd0;
    repeat (DB + 4) tick();
    chk("simul_cnt", int'(entry_cnt), 1);
    press(1);
    press(2);
    btn = 4'b1000;
    n = 0;
    while (state == CODE_ON && n < 30) begin
      tick();
      n++;
    end
    btn = 4'd0;
    chk("simul_open", int'(state), int'(CODE_OPEN));
    wait_on();

    press(2);
    press(1);
    chk("timeout_pre_cnt", int'(entry_cnt), 2);
    bz = 0;
    repeat (TO) begin
      tick();
      bz += int'(buzz);
    end
    chk("timeout_cnt", int'(entry_cnt), 0);
    chk("timeout_state", int'(state), int'(CODE_ON));
    chk("timeout_buzz", bz, 0);

    try_code(8'hFF, CODE_ERR, ERC, 1);
    try_code(8'hFF, CODE_ERR, ERC, 1);
    press(0);
    power_sw = 1'b0;
    n = 0;
    bz = 0;
    while (state != CODE_OFF && n < 20) begin
      tick();
      bz += int'(buzz);
      n++;
    end
    chk("pwr_off_state", int'(state), int'(CODE_OFF));
    chk("pwr_off_cnt", int'(entry_cnt), 0);
    chk("pwr_off_buzz", bz, 0);
    power_sw = 1'b1;
    wait_on();
    try_code(8'hFF, CODE_ERR, ERC, 1);

    press(1);
    chk("pre_reset_cnt", int'(entry_cnt), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(state), int'(CODE_OFF));
    chk("async_rst_cnt", int'(entry_cnt), 0);
    chk("async_rst_buzz", int'(buzz), 0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    wait_on();

    repeat (80) begin
      n = int'($urandom_range(0, 19));
      power_sw = (n != 0);
      if (n < 6) btn = 4'($urandom_range(0, 15));
      else if (n < 14) btn = 4'd1 << $urandom_range(0, 3);
      else btn = 4'd0;
      repeat ($urandom_range(1, 12)) tick();
    end
    power_sw = 1'b1;
    btn = 4'd0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
